// File: rtl/conv2d_3x3_stream_engine.sv
// Streaming 3x3 single-channel convolution: two line buffers plus a 3x3 window,
// NUM_FILTERS filters evaluated one per cycle, requantised results on a valid/ready stream.
//
// state   | meaning
// IDLE    | waiting for start, weights writable
// ACCEPT  | taking pixels into line buffers and window
// COMPUTE | one filter per output-register load for the current window
// FLUSH   | last beat of frame pending in the output register
module conv2d_3x3_stream_engine #(
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int NUM_FILTERS = 32,
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 20,
  parameter int SHIFT       = 0,
  localparam int AW = $clog2(NUM_FILTERS * 10),
  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int RW = $clog2(IMG_H),
  localparam int CW = $clog2(IMG_W)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     relu_en,
  input  logic                     w_we,
  input  logic [AW-1:0]            w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic signed [DATA_W-1:0] pix_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [FW-1:0]            out_filter,
  output logic [RW-1:0]            out_row,
  output logic [CW-1:0]            out_col,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_COMPUTE, S_FLUSH} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] wmem   [NUM_FILTERS*10];
  logic signed [DATA_W-1:0] lb_top [IMG_W];
  logic signed [DATA_W-1:0] lb_mid [IMG_W];
  logic signed [DATA_W-1:0] win    [9];

  logic          relu_q;
  logic [RW-1:0] in_row, pos_row;
  logic [CW-1:0] in_col, pos_col;
  logic [FW-1:0] filt;

  logic pix_fire, win_done, load, last_filt, last_pos, start_ok;
  logic signed [ACC_W-1:0]  acc, y, px, wt;
  logic signed [DATA_W-1:0] sat;
  logic [AW-1:0]            tap_base, bias_addr;

  assign start_ok  = (state == S_IDLE) && start && !done;
  assign pix_fire  = (state == S_ACCEPT) && pix_valid;
  assign win_done  = pix_fire && (in_row >= RW'(2)) && (in_col >= CW'(2));
  assign load      = (state == S_COMPUTE) && (!out_valid || out_ready);
  assign last_filt = (filt == FW'(NUM_FILTERS - 1));
  assign last_pos  = (pos_row == RW'(IMG_H - 3)) && (pos_col == CW'(IMG_W - 3));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_ok) state_nxt = S_ACCEPT;
      end
      S_ACCEPT: begin
        pix_ready = 1'b1;
        if (win_done) state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (load && last_filt) state_nxt = last_pos ? S_FLUSH : S_ACCEPT;
      end
      S_FLUSH: begin
        if (out_valid && out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Weights survive reset so a frame can be restarted without reloading.
  always_ff @(posedge clk) begin
    if (w_we && !busy) wmem[w_addr] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (pix_fire) begin
      lb_top[in_col] <= lb_mid[in_col];
      lb_mid[in_col] <= pix_data;
      win[0] <= win[1];  win[1] <= win[2];  win[2] <= lb_top[in_col];
      win[3] <= win[4];  win[4] <= win[5];  win[5] <= lb_mid[in_col];
      win[6] <= win[7];  win[7] <= win[8];  win[8] <= pix_data;
    end
  end

  always_comb begin
    tap_base  = AW'(filt) * AW'(9);
    bias_addr = AW'(NUM_FILTERS * 9) + AW'(filt);
    acc = {{(ACC_W-DATA_W){wmem[bias_addr][DATA_W-1]}}, wmem[bias_addr]};
    px  = '0;
    wt  = '0;
    for (int k = 0; k < 9; k++) begin
      px  = {{(ACC_W-DATA_W){win[k][DATA_W-1]}}, win[k]};
      wt  = {{(ACC_W-DATA_W){wmem[tap_base + AW'(k)][DATA_W-1]}}, wmem[tap_base + AW'(k)]};
      acc = acc + px * wt;
    end
    y = acc >>> SHIFT;
    if (relu_q && y[ACC_W-1]) y = '0;
    if (y > SAT_MAX)      sat = SAT_MAX[DATA_W-1:0];
    else if (y < SAT_MIN) sat = SAT_MIN[DATA_W-1:0];
    else                  sat = y[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      relu_q     <= 1'b0;
      in_row     <= '0;
      in_col     <= '0;
      pos_row    <= '0;
      pos_col    <= '0;
      filt       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_filter <= '0;
      out_row    <= '0;
      out_col    <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == S_FLUSH) && out_valid && out_ready;
      if (start_ok) begin
        relu_q <= relu_en;
        in_row <= '0;
        in_col <= '0;
      end
      if (pix_fire) begin
        if (in_col == CW'(IMG_W - 1)) begin
          in_col <= '0;
          in_row <= in_row + RW'(1);
        end else begin
          in_col <= in_col + CW'(1);
        end
        if (win_done) begin
          pos_row <= in_row - RW'(2);
          pos_col <= in_col - CW'(2);
          filt    <= '0;
        end
      end
      if (load) begin
        out_valid  <= 1'b1;
        out_data   <= sat;
        out_filter <= filt;
        out_row    <= pos_row;
        out_col    <= pos_col;
        out_last   <= last_filt && last_pos;
        filt       <= last_filt ? '0 : filt + FW'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv2d_3x3_stream_engine.sv
// Bench for conv2d_3x3_stream_engine: directed frames with randomised handshakes and data,
// every output beat compared against a direct 2-D convolution model.
module tb_conv2d_3x3_stream_engine;
  localparam int W = 6, H = 5, NF = 3, DW = 8, ACW = 20, SH = 2;
  localparam int AW = 5, FW = 2, RW = 3, CW = 3;
  localparam int P = (H - 2) * (W - 2);

  logic clk, reset, start, relu_en, w_we, pix_valid, pix_ready, out_valid, out_ready;
  logic out_last, busy, done;
  logic [AW-1:0] w_addr;
  logic signed [DW-1:0] w_data, pix_data, out_data;
  logic [FW-1:0] out_filter;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;

  int tests = 0, fails = 0;

  typedef struct { int data; int f; int r; int c; bit last; } beat_t;
  beat_t exp_q[$];
  int img[H][W];
  int wt[NF][9];
  int bs[NF];

  conv2d_3x3_stream_engine #(.IMG_W(W), .IMG_H(H), .NUM_FILTERS(NF), .DATA_W(DW),
                             .ACC_W(ACW), .SHIFT(SH)) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en), .w_we(w_we),
    .w_addr(w_addr), .w_data(w_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_filter(out_filter), .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .done(done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int ref_beat(int f, int r, int c, bit relu);
    int acc, y;
    acc = bs[f];
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        acc += img[r+ky][c+kx] * wt[f][ky*3+kx];
    y = acc >>> SH;
    if (relu && y < 0) y = 0;
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return y;
  endfunction

  function automatic void build_expected(bit relu);
    exp_q.delete();
    for (int r = 0; r < H - 2; r++)
      for (int c = 0; c < W - 2; c++)
        for (int f = 0; f < NF; f++)
          exp_q.push_back('{ref_beat(f, r, c, relu), f, r, c,
                            (f == NF-1) && (r == H-3) && (c == W-3)});
  endfunction

  // windows completed by the first pidx pixels of the frame
  function automatic int positions_done(int pidx);
    int rr, cc, n;
    rr = pidx / W;
    cc = pidx % W;
    n = (rr > 2) ? (rr - 2) * (W - 2) : 0;
    if (rr >= 2 && rr < H && cc > 2) n += cc - 2;
    return n;
  endfunction

  function automatic logic [63:0] obs_beat();
    return 64'({out_last, out_row, out_col, out_filter, out_data});
  endfunction

  task automatic load_weights();
    for (int a = 0; a < NF * 10; a++) begin
      @(negedge clk);
      w_we   = 1'b1;
      w_addr = AW'(a);
      w_data = (a < NF * 9) ? DW'(wt[a/9][a%9]) : DW'(bs[a - NF*9]);
    end
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic do_start(input bit relu);
    @(negedge clk);
    start = 1'b1;
    relu_en = relu;
    pix_valid = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_frame(input bit relu, input int rdy_pct, input int vld_pct,
                           input bit junk, input int rst_after, input bit full_rate);
    int pidx, beats, dones, cyc;
    bit held, finished;
    logic [63:0] hold_val;
    beat_t e;
    build_expected(relu);
    do_start(relu);
    pidx = 0; beats = 0; dones = 0; cyc = 0; held = 0; finished = 0; hold_val = '0;
    while (!finished && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      w_we  = 1'b0;
      if (done) begin
        dones++;
        chk("busy_low_at_done", busy, 0);
        chk("out_valid_low_at_done", out_valid, 0);
        chk("beats_left_at_done", exp_q.size(), 0);
        chk("pixels_taken_at_done", pidx, H * W);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_cycle_ignored", {busy, done}, 0);
        finished = 1;
      end else begin
        if (held) chk("stall_hold", obs_beat(), hold_val);
        if (pix_ready) chk("pix_ready_only_when_drained", positions_done(pidx) * NF - beats, out_valid);
        out_ready = ($urandom_range(99) < rdy_pct);
        pix_valid = (pidx < H * W) && ($urandom_range(99) < vld_pct);
        pix_data  = (pidx < H * W) ? DW'(img[pidx/W][pidx%W]) : DW'($urandom);
        relu_en   = $urandom_range(1);
        if (junk) begin
          start  = ($urandom_range(3) == 0);
          w_we   = ($urandom_range(3) == 0);
          w_addr = AW'(4);
          w_data = DW'(99);
        end
        if (out_valid && out_ready) begin
          chk("beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat", obs_beat(), 64'({e.last, RW'(e.r), CW'(e.c), FW'(e.f), DW'(e.data)}));
          end
          beats++;
        end
        held = out_valid && !out_ready;
        hold_val = obs_beat();
        if (pix_valid && pix_ready) pidx++;
        if (rst_after > 0 && beats == rst_after) begin
          #2 reset = 1'b1;
          #1 chk("reset_mid_frame_values",
                 {pix_ready, out_valid, out_data, out_filter, out_row, out_col, out_last, busy, done}, 0);
          @(negedge clk);
          reset = 1'b0; out_ready = 1'b0; pix_valid = 1'b0; start = 1'b0; w_we = 1'b0;
          return;
        end
      end
    end
    chk("frame_done_seen", dones, 1);
    if (full_rate) chk("full_rate_cycles", cyc, H * W + P * NF + 2);
    start = 1'b0; w_we = 1'b0; pix_valid = 1'b0;
  endtask

  task automatic set_identity();
    for (int f = 0; f < NF; f++) begin
      for (int k = 0; k < 9; k++) wt[f][k] = (k == 4) ? 1 : 0;
      bs[f] = f;
    end
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = r + c;
  endtask

  initial begin
    reset = 1'b1; start = 0; relu_en = 0; w_we = 0; w_addr = '0; w_data = '0;
    pix_valid = 0; pix_data = '0; out_ready = 0;
    #2 chk("reset_values",
           {pix_ready, out_valid, out_data, out_filter, out_row, out_col, out_last, busy, done}, 0);
    #20;
    @(negedge clk) reset = 1'b0;

    // identity filters, full rate
    set_identity();
    load_weights();
    run_frame(0, 100, 100, 0, 0, 1);

    // saturation, relu and arithmetic shift of a negative accumulator
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 127;
    for (int k = 0; k < 9; k++) begin
      wt[0][k] = 127;
      wt[1][k] = -128;
      wt[2][k] = (k == 4) ? -1 : 0;
    end
    bs[0] = 0; bs[1] = 0; bs[2] = -2;
    load_weights();
    run_frame(0, 100, 100, 0, 0, 1);
    run_frame(1, 100, 100, 0, 0, 1);

    // backpressure with junk start and weight writes while busy
    set_identity();
    load_weights();
    run_frame(0, 30, 60, 1, 0, 0);
    run_frame(0, 100, 100, 0, 0, 1);

    // reset mid-frame, then a full frame without reloading weights
    run_frame(0, 70, 80, 0, 15, 0);
    run_frame(0, 60, 90, 0, 0, 0);

    // random weights and pixels
    for (int n = 0; n < 3; n++) begin
      for (int f = 0; f < NF; f++) begin
        for (int k = 0; k < 9; k++) wt[f][k] = int'($urandom_range(255)) - 128;
        bs[f] = int'($urandom_range(255)) - 128;
      end
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++)
        img[r][c] = int'($urandom_range(255)) - 128;
      load_weights();
      run_frame(n[0], 50 + 20 * n, 70, 1, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
